// File: rtl/resp_mon_pkg.sv
// Shared types and helpers for the response-window monitor.
package resp_mon_pkg;

    // Per-channel attempt state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

    // Add two values and clamp the result at max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end else begin
            return sum[31:0];
        end
    endfunction

    // Number of set bits; channel vectors are zero-extended to 32 bits.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/resp_window_ch.sv
// One monitor channel: trigger edge detect, response-window FSM with its
// delay counter, and the consecutive-high run counter for resp.
module resp_window_ch
    import resp_mon_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 5,
    parameter int RUN_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic trig,
    input  logic resp,
    output logic busy,
    output logic pass_pulse,
    output logic fail_pulse,
    output logic ovl_pulse,
    output logic run_viol,
    output logic pass_evt,
    output logic fail_evt,
    output logic viol_evt
);

    localparam int KW = $clog2(MAX_DLY + 1);
    localparam int RW = $clog2(RUN_LEN + 1);

    ch_state_e         state_r, state_n_s;
    logic [KW-1:0]     k_r, k_n_s;
    logic [RW-1:0]     run_r, run_n_s;
    logic              trig_q_r;
    logic              rise_s;
    logic              pass_s, fail_s, ovl_s, viol_s;
    logic              pass_r, fail_r, ovl_r, viol_r;

    assign rise_s = trig & ~trig_q_r;

    // Window FSM: a rise on the deciding cycle re-arms directly instead of overlapping.
    always_comb begin
        state_n_s = state_r;
        k_n_s     = k_r;
        pass_s    = 1'b0;
        fail_s    = 1'b0;
        ovl_s     = 1'b0;
        if (!en) begin
            state_n_s = IDLE;
            k_n_s     = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_n_s = WAIT;
                        k_n_s     = KW'(1);
                    end else begin
                        k_n_s     = '0;
                    end
                end
                WAIT: begin
                    if (resp && (k_r >= KW'(MIN_DLY))) begin
                        pass_s = 1'b1;
                    end else if (k_r == KW'(MAX_DLY)) begin
                        fail_s = 1'b1;
                    end else begin
                        pass_s = 1'b0;
                    end
                    if (pass_s || fail_s) begin
                        if (rise_s) begin
                            state_n_s = WAIT;
                            k_n_s     = KW'(1);
                        end else begin
                            state_n_s = IDLE;
                            k_n_s     = '0;
                        end
                    end else begin
                        k_n_s = k_r + KW'(1);
                        ovl_s = rise_s;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    k_n_s     = '0;
                end
            endcase
        end
    end

    // Run counter saturates at RUN_LEN; every further high cycle is a violation.
    always_comb begin
        run_n_s = run_r;
        viol_s  = 1'b0;
        if (!en || !resp) begin
            run_n_s = '0;
        end else if (run_r == RW'(RUN_LEN)) begin
            viol_s  = 1'b1;
        end else begin
            run_n_s = run_r + RW'(1);
        end
    end

    // State, counters, edge-detect history and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            k_r      <= '0;
            run_r    <= '0;
            trig_q_r <= 1'b0;
            pass_r   <= 1'b0;
            fail_r   <= 1'b0;
            ovl_r    <= 1'b0;
            viol_r   <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            k_r      <= k_n_s;
            run_r    <= run_n_s;
            trig_q_r <= trig;
            pass_r   <= pass_s;
            fail_r   <= fail_s;
            ovl_r    <= ovl_s;
            viol_r   <= viol_s;
        end
    end

    assign busy       = (state_r == WAIT);
    assign pass_pulse = pass_r;
    assign fail_pulse = fail_r;
    assign ovl_pulse  = ovl_r;
    assign run_viol   = viol_r;

    // Unregistered verdicts so the top-level counters land with the pulses.
    assign pass_evt = pass_s;
    assign fail_evt = fail_s;
    assign viol_evt = viol_s;

endmodule

// File: rtl/resp_window_monitor.sv
// Multi-channel bounded-response / run-length monitor with saturating
// pass and fail event counters.
module resp_window_monitor
    import resp_mon_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 5,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   resp,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   pass_pulse,
    output logic [NCH-1:0]   fail_pulse,
    output logic [NCH-1:0]   ovl_pulse,
    output logic [NCH-1:0]   run_viol,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << CNT_W) - 32'd1);

    logic [NCH-1:0]   pass_evt_s, fail_evt_s, viol_evt_s;
    logic [31:0]      pass_inc_s, fail_inc_s;
    logic [CNT_W-1:0] pass_cnt_r, fail_cnt_r;
    logic [CNT_W-1:0] pass_cnt_n_s, fail_cnt_n_s;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        resp_window_ch #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .RUN_LEN (RUN_LEN)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .trig       (trig[g]),
            .resp       (resp[g]),
            .busy       (busy[g]),
            .pass_pulse (pass_pulse[g]),
            .fail_pulse (fail_pulse[g]),
            .ovl_pulse  (ovl_pulse[g]),
            .run_viol   (run_viol[g]),
            .pass_evt   (pass_evt_s[g]),
            .fail_evt   (fail_evt_s[g]),
            .viol_evt   (viol_evt_s[g])
        );
    end

    // Counter next values: clear wins over same-cycle increments.
    always_comb begin
        pass_inc_s = popcount(32'(pass_evt_s));
        fail_inc_s = popcount(32'(fail_evt_s)) + popcount(32'(viol_evt_s));
        if (clr) begin
            pass_cnt_n_s = '0;
            fail_cnt_n_s = '0;
        end else begin
            pass_cnt_n_s = CNT_W'(sat_add(32'(pass_cnt_r), pass_inc_s, CNT_MAX));
            fail_cnt_n_s = CNT_W'(sat_add(32'(fail_cnt_r), fail_inc_s, CNT_MAX));
        end
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else begin
            pass_cnt_r <= pass_cnt_n_s;
            fail_cnt_r <= fail_cnt_n_s;
        end
    end

    assign pass_cnt = pass_cnt_r;
    assign fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_resp_window_monitor.sv
// Scoreboard bench: stimulus queues expected pulse vectors by cycle, a
// negedge monitor pops and compares whenever any pulse output is active.
module tb_resp_window_monitor;

    logic        clk = 1'b0;
    logic        rst_n, en, clr;
    logic [3:0]  trig, resp;
    logic [3:0]  busy, pass_pulse, fail_pulse, ovl_pulse, run_viol;
    logic [15:0] pass_cnt, fail_cnt;

    resp_window_monitor #(
        .NCH(4), .MIN_DLY(1), .MAX_DLY(5), .RUN_LEN(3), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .trig       (trig),
        .resp       (resp),
        .busy       (busy),
        .pass_pulse (pass_pulse),
        .fail_pulse (fail_pulse),
        .ovl_pulse  (ovl_pulse),
        .run_viol   (run_viol),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int b;

    typedef struct {
        int          cyc;
        logic [15:0] vec;   // {pass, fail, ovl, viol}
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [15:0] ev(input logic [3:0] p, input logic [3:0] f,
                                       input logic [3:0] o, input logic [3:0] v);
        return {p, f, o, v};
    endfunction

    task automatic expect_at(input int c, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: any active pulse must match the oldest expected {cycle, vector}.
    always @(negedge clk) begin
        if (rst_n && ({pass_pulse, fail_pulse, ovl_pulse, run_viol} != 16'd0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {cyc[15:0], pass_pulse, fail_pulse, ovl_pulse, run_viol}, 32'd0);
            end else begin
                check("pulse_event", {cyc[15:0], pass_pulse, fail_pulse, ovl_pulse, run_viol},
                      {sb[0].cyc[15:0], sb[0].vec});
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; trig = 4'd0; resp = 4'd0;
        ticks(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("rst_pulses", 32'({pass_pulse, fail_pulse, ovl_pulse, run_viol}), 32'd0);
        rst_n = 1'b1;
        ticks(3);

        // Pass at the lower bound on ch0.
        b = cyc;
        expect_at(b + 2, ev(4'b0001, 4'd0, 4'd0, 4'd0));
        trig = 4'b0001; tick();
        trig = 4'd0; resp = 4'b0001;
        check("s1_busy", 32'(busy), 32'h1);
        tick();
        resp = 4'd0;
        check("s1_pass_cnt", 32'(pass_cnt), 32'd1);
        check("s1_fail_cnt", 32'(fail_cnt), 32'd0);
        check("s1_busy_drop", 32'(busy), 32'd0);
        ticks(3);

        // Response on the trigger cycle is ignored; window expires.
        b = cyc;
        expect_at(b + 6, ev(4'd0, 4'b0001, 4'd0, 4'd0));
        trig = 4'b0001; resp = 4'b0001; tick();
        trig = 4'd0; resp = 4'd0; ticks(5);
        check("s2_fail_cnt", 32'(fail_cnt), 32'd1);
        ticks(3);

        // Overlap drop, then back-to-back restart on the deciding cycle.
        b = cyc;
        expect_at(b + 4, ev(4'd0, 4'd0, 4'b0001, 4'd0));
        expect_at(b + 6, ev(4'd0, 4'b0001, 4'd0, 4'd0));
        expect_at(b + 8, ev(4'b0001, 4'd0, 4'd0, 4'd0));
        trig = 4'b0001; tick();
        trig = 4'd0; ticks(2);
        trig = 4'b0001; tick();
        trig = 4'd0;
        check("s3_busy_ovl", 32'(busy), 32'h1);
        tick();
        trig = 4'b0001; tick();
        trig = 4'd0;
        check("s3_busy_b2b", 32'(busy), 32'h1);
        check("s3_fail_cnt", 32'(fail_cnt), 32'd2);
        tick();
        resp = 4'b0001; tick();
        resp = 4'd0;
        check("s3_pass_cnt", 32'(pass_cnt), 32'd2);
        check("s3_busy_end", 32'(busy), 32'd0);
        ticks(3);

        // Run-length: five consecutive highs give two violations.
        b = cyc;
        expect_at(b + 4, ev(4'd0, 4'd0, 4'd0, 4'b0001));
        expect_at(b + 5, ev(4'd0, 4'd0, 4'd0, 4'b0001));
        resp = 4'b0001; ticks(5);
        resp = 4'd0;
        check("s4_fail_cnt", 32'(fail_cnt), 32'd4);
        ticks(3);

        // All four channels fail together.
        b = cyc;
        expect_at(b + 6, ev(4'd0, 4'hF, 4'd0, 4'd0));
        trig = 4'hF; tick();
        trig = 4'd0; ticks(5);
        check("s5_fail_cnt", 32'(fail_cnt), 32'd8);
        ticks(3);

        // Response exactly at MAX_DLY passes on ch1.
        b = cyc;
        expect_at(b + 6, ev(4'b0010, 4'd0, 4'd0, 4'd0));
        trig = 4'b0010; tick();
        trig = 4'd0; ticks(4);
        resp = 4'b0010; tick();
        resp = 4'd0;
        check("s6_pass_cnt", 32'(pass_cnt), 32'd3);
        check("s6_fail_cnt", 32'(fail_cnt), 32'd8);
        ticks(3);

        // Clear concurrent with a pass decision.
        b = cyc;
        expect_at(b + 2, ev(4'b1000, 4'd0, 4'd0, 4'd0));
        trig = 4'b1000; tick();
        trig = 4'd0; resp = 4'b1000; clr = 1'b1; tick();
        resp = 4'd0; clr = 1'b0;
        check("s7_pass_cnt", 32'(pass_cnt), 32'd0);
        check("s7_fail_cnt", 32'(fail_cnt), 32'd0);
        ticks(3);

        // Reset mid-attempt, then trig held high out of reset counts as a rise.
        trig = 4'b0001; tick();
        trig = 4'd0; ticks(2);
        check("s8_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("s8_busy_rst", 32'(busy), 32'd0);
        ticks(2);
        trig = 4'b0010; tick();
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 2, ev(4'b0010, 4'd0, 4'd0, 4'd0));
        tick();
        resp = 4'b0010; tick();
        resp = 4'd0;
        check("s8_pass_cnt", 32'(pass_cnt), 32'd1);
        check("s8_fail_cnt", 32'(fail_cnt), 32'd0);
        ticks(3);

        // Enable low discards an attempt and suppresses run checks.
        trig = 4'b0110; tick();
        check("s9_busy_run", 32'(busy), 32'h4);
        tick();
        en = 1'b0; resp = 4'b0001; tick();
        check("s9_busy_dis", 32'(busy), 32'd0);
        ticks(4);
        resp = 4'd0; en = 1'b1; ticks(8);
        check("s9_busy_reen", 32'(busy), 32'd0);
        check("s9_fail_cnt", 32'(fail_cnt), 32'd0);
        trig = 4'd0; tick();

        // Saturation: four run violations per cycle until fail_cnt clamps.
        b = cyc;
        for (int c = 4; c <= 16403; c++) expect_at(b + c, ev(4'd0, 4'd0, 4'd0, 4'hF));
        resp = 4'hF;
        for (int i = 1; i <= 16403; i++) begin
            tick();
            if (i == 103) check("s10_fail_mid", 32'(fail_cnt), 32'd400);
        end
        resp = 4'd0;
        check("s10_fail_sat", 32'(fail_cnt), 32'd65535);
        check("s10_pass_keep", 32'(pass_cnt), 32'd1);
        ticks(3);
        check("s10_fail_stick", 32'(fail_cnt), 32'd65535);
        clr = 1'b1; tick();
        clr = 1'b0;
        check("s10_clr_fail", 32'(fail_cnt), 32'd0);
        check("s10_clr_pass", 32'(pass_cnt), 32'd0);
        ticks(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
